output_deskew: RTL and testbench
================================

# output_deskew

Collects the time-skewed accumulator outputs leaving the bottom of the 2x2 systolic array and reassembles them into an aligned 2x2 result matrix. Column 1 emits its two results one cycle ahead of column 2, so this block de-skews the two streams independently. It presents the full matrix to the downstream consumer under a valid/ready handshake. It sits between the array's bottom-row outputs and the result writeback path, and undoes the skew the array applies on its inputs.

## Interface
- DATA_WIDTH, 16, width of each accumulator result and matrix element.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  arms a collection; sampled only in IDLE, or in HOLD together with an accepted handshake.
- acc_in1  input  DATA_WIDTH  column-1 accumulator output (c11, then c21).
- acc_valid1  input  1  qualifies acc_in1.
- acc_in2  input  DATA_WIDTH  column-2 accumulator output (c12, then c22).
- acc_valid2  input  1  qualifies acc_in2.
- result_ready  input  1  consumer accepts the matrix.
- c11, c12, c21, c22  output  DATA_WIDTH each  assembled result registers.
- result_valid  output  1  matrix complete and stable.
- busy  output  1  high in COLLECT.
- drop_err  output  1  sticky flag: a valid beat was discarded.

## Operation
- State register: IDLE, COLLECT, HOLD. Each column has a 2-bit row counter, cnt1 and cnt2, with a range of 0..2.
- IDLE:
  - If start=1: go to COLLECT, clear cnt1 and cnt2, clear drop_err.
  - Any acc_valid beat is discarded and sets drop_err.
- COLLECT:
  - If acc_valid1 and cnt1<2: write acc_in1 to c11 when cnt1=0 or to c21 when cnt1=1, then increment cnt1.
  - Column 2 works the same way with cnt2, writing c12 and then c22.
  - The two columns are fully independent. A simultaneous beat on both columns is captured in the same cycle.
  - A beat on a column whose counter is already 2 is discarded and sets drop_err.
  - Transition to HOLD on the edge where both counters become (or already are) 2.
  - start is ignored in COLLECT.
- HOLD:
  - result_valid=1. c11..c22 must not change.
  - acc_valid beats are discarded and set drop_err.
  - If result_ready=1 and start=0: go to IDLE.
  - If result_ready=1 and start=1: go to COLLECT, clear the counters, clear drop_err.
  - If result_ready=0: stay in HOLD indefinitely.
- Outputs c11..c22 are holding registers. They keep their last values outside capture events, and are meaningful only while result_valid=1.
- No arithmetic is performed. Data passes through bit-exact; there is no truncation or sign handling.
- drop_err stays set until the next accepted start or until reset.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, cnt1=cnt2=0, c11=c12=c21=c22=0, result_valid=0, busy=0, drop_err=0. This takes effect immediately, including mid-COLLECT or mid-HOLD. Any partial matrix is lost.
- start is sampled at edge N. busy=1 from edge N. Capture is possible at edge N+1 onward.
- Each capture is registered at the edge where acc_validX=1 is sampled.
- For the nominal skew (column 1 beats at T and T+1, column 2 beats at T+1 and T+2), result_valid rises at edge T+2, with zero added latency after the final capture.
- Handshake transfer completes at the edge where result_valid=1 and result_ready=1. result_valid falls at that edge unless start re-arms, and in that case it still falls.
- Back-to-back matrices are possible with no idle cycle, using start and result_ready together in HOLD.
- result_valid and busy are mutually exclusive.

## Test plan
- Nominal skew:
  - Stimulus: start at cycle 0; acc1=0x0011 (cycle 1), acc1=0x0021 and acc2=0x0012 (cycle 2), acc2=0x0022 (cycle 3); result_ready=1.
  - Required response: result_valid high for exactly one cycle after the cycle-3 edge, with c11=0x0011, c12=0x0012, c21=0x0021, c22=0x0022; drop_err=0.
- Backpressure:
  - Stimulus: same beats as the nominal case, result_ready=0 for 5 cycles, then 1.
  - Required response: result_valid held for 6 cycles, outputs constant throughout, then IDLE.
- Extra beat:
  - Stimulus: a third acc_valid1 (0xBEEF) in COLLECT after cnt1=2, before column 2 completes.
  - Required response: c21 unchanged, drop_err=1, matrix still completes correctly.
- Stray beat:
  - Stimulus: acc_valid2 pulse in IDLE.
  - Required response: drop_err=1 and no capture. The next start clears drop_err to 0.
- Reset mid-operation:
  - Stimulus: reset_n low for one cycle after a single column-1 capture.
  - Required response: all outputs 0 immediately. A subsequent full sequence with values 1,2,3,4 yields c11=1, c12=2, c21=3, c22=4.
- Back-to-back matrices:
  - Stimulus: in HOLD, assert result_ready and start together, then drive a second matrix 0x0A..0x0D.
  - Required response: busy=1 the next cycle, and the second result_valid presents 0x0A..0x0D with no intervening IDLE cycle.

Source files
------------

// File: rtl/output_deskew.sv
// Reassembles the skewed bottom-row accumulator streams of a 2x2 systolic array
// into an aligned result matrix presented under a valid/ready handshake.
module output_deskew #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] acc_in1,
  input  logic                  acc_valid1,
  input  logic [DATA_WIDTH-1:0] acc_in2,
  input  logic                  acc_valid2,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] c11,
  output logic [DATA_WIDTH-1:0] c12,
  output logic [DATA_WIDTH-1:0] c21,
  output logic [DATA_WIDTH-1:0] c22,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  drop_err
);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [1:0]            cnt1_q, cnt1_d;
  logic [1:0]            cnt2_q, cnt2_d;
  logic [DATA_WIDTH-1:0] c11_q, c11_d;
  logic [DATA_WIDTH-1:0] c12_q, c12_d;
  logic [DATA_WIDTH-1:0] c21_q, c21_d;
  logic [DATA_WIDTH-1:0] c22_q, c22_d;
  logic                  drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    c11_d   = c11_q;
    c12_d   = c12_q;
    c21_d   = c21_q;
    c22_d   = c22_q;
    drop_d  = drop_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCollect;
          cnt1_d  = 2'd0;
          cnt2_d  = 2'd0;
          drop_d  = 1'b0;
        end
        // A beat arriving alongside start is still discarded, so set wins over clear.
        if (acc_valid1 || acc_valid2) begin
          drop_d = 1'b1;
        end
      end

      StCollect: begin
        if (acc_valid1) begin
          if (cnt1_q == 2'd0) begin
            c11_d  = acc_in1;
            cnt1_d = 2'd1;
          end else if (cnt1_q == 2'd1) begin
            c21_d  = acc_in1;
            cnt1_d = 2'd2;
          end else begin
            drop_d = 1'b1;
          end
        end

        if (acc_valid2) begin
          if (cnt2_q == 2'd0) begin
            c12_d  = acc_in2;
            cnt2_d = 2'd1;
          end else if (cnt2_q == 2'd1) begin
            c22_d  = acc_in2;
            cnt2_d = 2'd2;
          end else begin
            drop_d = 1'b1;
          end
        end

        // Enter HOLD on the same edge as the final capture: no added latency.
        if (cnt1_d == 2'd2 && cnt2_d == 2'd2) begin
          state_d = StHold;
        end
      end

      StHold: begin
        if (result_ready) begin
          if (start) begin
            state_d = StCollect;
            cnt1_d  = 2'd0;
            cnt2_d  = 2'd0;
            drop_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
        if (acc_valid1 || acc_valid2) begin
          drop_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt1_q  <= 2'd0;
      cnt2_q  <= 2'd0;
      c11_q   <= '0;
      c12_q   <= '0;
      c21_q   <= '0;
      c22_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      c11_q   <= c11_d;
      c12_q   <= c12_d;
      c21_q   <= c21_d;
      c22_q   <= c22_d;
      drop_q  <= drop_d;
    end
  end

  assign c11          = c11_q;
  assign c12          = c12_q;
  assign c21          = c21_q;
  assign c22          = c22_q;
  assign result_valid = (state_q == StHold);
  assign busy         = (state_q == StCollect);
  assign drop_err     = drop_q;

  a_valid_busy_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(result_valid && busy));

  a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
    (cnt1_q <= 2'd2) && (cnt2_q <= 2'd2));

  a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StHold) |=> $stable({c11_q, c12_q, c21_q, c22_q}));

endmodule

// File: tb/tb_output_deskew.sv
// Self-checking bench for output_deskew: table-driven matrices plus hand-written
// corner sequences, with expected matrices queued at stimulus time.
module tb_output_deskew;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [DW-1:0] acc_in1;
  logic          acc_valid1;
  logic [DW-1:0] acc_in2;
  logic          acc_valid2;
  logic          result_ready;
  logic [DW-1:0] c11, c12, c21, c22;
  logic          result_valid;
  logic          busy;
  logic          drop_err;

  output_deskew #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .acc_in1      (acc_in1),
    .acc_valid1   (acc_valid1),
    .acc_in2      (acc_in2),
    .acc_valid2   (acc_valid2),
    .result_ready (result_ready),
    .c11          (c11),
    .c12          (c12),
    .c21          (c21),
    .c22          (c22),
    .result_valid (result_valid),
    .busy         (busy),
    .drop_err     (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] c11;
    logic [DW-1:0] c12;
    logic [DW-1:0] c21;
    logic [DW-1:0] c22;
  } mat_t;

  typedef struct {
    logic [DW-1:0] a11;
    logic [DW-1:0] a12;
    logic [DW-1:0] a21;
    logic [DW-1:0] a22;
    int            ready_delay;
    logic [DW-1:0] e11;
    logic [DW-1:0] e12;
    logic [DW-1:0] e21;
    logic [DW-1:0] e22;
    logic          e_drop;
  } vec_t;

  mat_t exp_q[$];
  mat_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] e11, input logic [DW-1:0] e12,
                          input logic [DW-1:0] e21, input logic [DW-1:0] e22);
    mat_t m;
    m.c11 = e11;
    m.c12 = e12;
    m.c21 = e21;
    m.c22 = e22;
    exp_q.push_back(m);
  endtask

  // Pops the next expected matrix into cur and compares the DUT outputs against it.
  task automatic check_matrix(input string tag);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_queue: got empty scoreboard, expected a pending matrix", tag);
    end else begin
      cur = exp_q.pop_front();
      check({tag, "_c11"}, 32'(c11), 32'(cur.c11));
      check({tag, "_c12"}, 32'(c12), 32'(cur.c12));
      check({tag, "_c21"}, 32'(c21), 32'(cur.c21));
      check({tag, "_c22"}, 32'(c22), 32'(cur.c22));
    end
  endtask

  // Nominal skew: column 1 at T and T+1, column 2 at T+1 and T+2.
  task automatic drive_beats(input logic [DW-1:0] a11, input logic [DW-1:0] a12,
                             input logic [DW-1:0] a21, input logic [DW-1:0] a22);
    acc_valid1 = 1'b1;
    acc_in1    = a11;
    tick();
    acc_in1    = a21;
    acc_valid2 = 1'b1;
    acc_in2    = a12;
    tick();
    acc_valid1 = 1'b0;
    acc_in2    = a22;
    tick();
    acc_valid2 = 1'b0;
  endtask

  task automatic arm(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_valid_lo"}, 32'(result_valid), 32'd0);
  endtask

  task automatic accept(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_valid_fall"}, 32'(result_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{16'h0011, 16'h0012, 16'h0021, 16'h0022, 0,
                16'h0011, 16'h0012, 16'h0021, 16'h0022, 1'b0};
    vecs[1] = '{16'h0011, 16'h0012, 16'h0021, 16'h0022, 5,
                16'h0011, 16'h0012, 16'h0021, 16'h0022, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFE, 2,
                16'hFFFF, 16'h8000, 16'h0001, 16'h7FFE, 1'b0};

    reset_n      = 1'b0;
    start        = 1'b0;
    acc_in1      = '0;
    acc_valid1   = 1'b0;
    acc_in2      = '0;
    acc_valid2   = 1'b0;
    result_ready = 1'b0;

    #3;
    check("rst_c11", 32'(c11), 32'd0);
    check("rst_c22", 32'(c22), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_err), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      arm(tag);
      push_exp(vecs[i].e11, vecs[i].e12, vecs[i].e21, vecs[i].e22);
      drive_beats(vecs[i].a11, vecs[i].a12, vecs[i].a21, vecs[i].a22);
      check({tag, "_valid"}, 32'(result_valid), 32'd1);
      check_matrix(tag);
      check({tag, "_drop"}, 32'(drop_err), 32'(vecs[i].e_drop));
      for (int k = 0; k < vecs[i].ready_delay; k++) begin
        result_ready = 1'b0;
        tick();
        check($sformatf("%s_hold%0d_valid", tag, k), 32'(result_valid), 32'd1);
        check($sformatf("%s_hold%0d_c", tag, k), {c11, c22} ^ {c12, c21},
              {cur.c11, cur.c22} ^ {cur.c12, cur.c21});
        check($sformatf("%s_hold%0d_c11", tag, k), 32'(c11), 32'(cur.c11));
      end
      accept(tag);
    end

    // Extra column-1 beat after cnt1 reached 2.
    arm("extra");
    push_exp(16'h0011, 16'h0012, 16'h0021, 16'h0022);
    acc_valid1 = 1'b1;
    acc_in1    = 16'h0011;
    tick();
    acc_in1    = 16'h0021;
    acc_valid2 = 1'b1;
    acc_in2    = 16'h0012;
    tick();
    acc_valid2 = 1'b0;
    acc_in1    = 16'hBEEF;
    tick();
    check("extra_c21_kept", 32'(c21), 32'h0021);
    check("extra_drop", 32'(drop_err), 32'd1);
    check("extra_still_busy", 32'(busy), 32'd1);
    acc_valid1 = 1'b0;
    acc_valid2 = 1'b1;
    acc_in2    = 16'h0022;
    tick();
    acc_valid2 = 1'b0;
    check("extra_valid", 32'(result_valid), 32'd1);
    check_matrix("extra");
    check("extra_drop_held", 32'(drop_err), 32'd1);
    accept("extra");

    // Stray column-2 beat in IDLE; start must clear the flag.
    arm("clr");
    push_exp(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    drive_beats(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    check_matrix("clr");
    check("clr_drop", 32'(drop_err), 32'd0);
    accept("clr");
    acc_valid2 = 1'b1;
    acc_in2    = 16'h7777;
    tick();
    acc_valid2 = 1'b0;
    check("stray_drop", 32'(drop_err), 32'd1);
    check("stray_no_capture", 32'(c12), 32'h2222);
    check("stray_idle", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("stray_start_clears", 32'(drop_err), 32'd0);
    check("stray_start_busy", 32'(busy), 32'd1);

    // Reset after a single column-1 capture.
    acc_valid1 = 1'b1;
    acc_in1    = 16'h0055;
    tick();
    acc_valid1 = 1'b0;
    check("rmid_c11_captured", 32'(c11), 32'h0055);
    #2;
    reset_n = 1'b0;
    #1;
    check("rmid_c11", 32'(c11), 32'd0);
    check("rmid_c12", 32'(c12), 32'd0);
    check("rmid_c21", 32'(c21), 32'd0);
    check("rmid_c22", 32'(c22), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_valid", 32'(result_valid), 32'd0);
    check("rmid_drop", 32'(drop_err), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    arm("post_rst");
    push_exp(16'd1, 16'd2, 16'd3, 16'd4);
    drive_beats(16'd1, 16'd2, 16'd3, 16'd4);
    check("post_rst_valid", 32'(result_valid), 32'd1);
    check_matrix("post_rst");

    // Back-to-back: accept and re-arm in the same HOLD cycle.
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid_lo", 32'(result_valid), 32'd0);
    push_exp(16'h000A, 16'h000B, 16'h000C, 16'h000D);
    acc_valid1 = 1'b1;
    acc_in1    = 16'h000A;
    tick();
    check("b2b_busy1", 32'(busy), 32'd1);
    acc_in1    = 16'h000C;
    acc_valid2 = 1'b1;
    acc_in2    = 16'h000B;
    tick();
    check("b2b_busy2", 32'(busy), 32'd1);
    acc_valid1 = 1'b0;
    acc_in2    = 16'h000D;
    tick();
    acc_valid2 = 1'b0;
    check("b2b_valid", 32'(result_valid), 32'd1);
    check_matrix("b2b");
    check("b2b_drop", 32'(drop_err), 32'd0);
    accept("b2b");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
